// File: rtl/tdc_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package : tdc_pkg
// Shared FSM state type, default parameter constants and width helper for the
// TDC burst reader.
// Revision: 1.0 - initial release
// ============================================================================
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_OUTPUT  = 3'd4,
        S_RECOVER = 3'd5,
        S_FINISH  = 3'd6
    } tdc_state_t;

    localparam int c_DEF_DATA_W     = 28;
    localparam int c_DEF_ADDR_W     = 4;
    localparam int c_DEF_N_FIFO     = 2;
    localparam int c_DEF_FIFO_ADDR0 = 8;
    localparam int c_DEF_SETUP_CYC  = 1;
    localparam int c_DEF_RD_LOW_CYC = 2;
    localparam int c_DEF_REC_CYC    = 3;
    localparam int c_DEF_MAX_BURST  = 16;

    // Width able to hold values 0..n-1, never narrower than one bit.
    function automatic int tdc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tdc_rr_arbiter
// Round-robin pick of the first non-empty FIFO at or after the pointer.
// Revision: 1.0 - initial release
// ============================================================================
module tdc_rr_arbiter #(
    parameter int N_FIFO = 2,
    parameter int IDX_W  = 1
) (
    input  logic [N_FIFO-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    localparam int c_SW = IDX_W + 1;

    logic [2*N_FIFO-1:0] w_dbl;
    logic [2*N_FIFO-1:0] w_rot;
    logic [c_SW-1:0]     w_sum;

    assign w_dbl = {i_req, i_req};
    // Rotating the doubled mask puts the pointer's FIFO at bit 0.
    assign w_rot = w_dbl >> i_ptr;

    always_comb begin
        o_any = 1'b0;
        w_sum = '0;
        for (int k = 0; k < N_FIFO; k++) begin
            if (!o_any && w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + c_SW'(k);
                o_any = 1'b1;
            end
        end
        if (w_sum >= c_SW'(N_FIFO)) begin
            w_sum = w_sum - c_SW'(N_FIFO);
        end
        o_idx = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/tdc_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : tdc_burst_reader
// Reads single words or drains bursts from TDC FIFOs with a timed CSN/RDN cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tdc_burst_reader
    import tdc_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int N_FIFO     = c_DEF_N_FIFO,
    parameter int FIFO_ADDR0 = c_DEF_FIFO_ADDR0,
    parameter int SETUP_CYC  = c_DEF_SETUP_CYC,
    parameter int RD_LOW_CYC = c_DEF_RD_LOW_CYC,
    parameter int REC_CYC    = c_DEF_REC_CYC,
    parameter int MAX_BURST  = c_DEF_MAX_BURST
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                burst,
    input  logic [N_FIFO-1:0]                   ef,
    input  logic [DATA_W-1:0]                   tdc_data,
    output logic [ADDR_W-1:0]                   tdc_addr,
    output logic                                tdc_csn,
    output logic                                tdc_rdn,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [DATA_W-1:0]                   m_data,
    output logic [tdc_width(N_FIFO)-1:0]        m_chan,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(MAX_BURST+1)-1:0]      word_cnt,
    output logic                                alu_trigger
);

    localparam int c_CHAN_W  = tdc_width(N_FIFO);
    localparam int c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam int c_TMR_MAX = (SETUP_CYC > RD_LOW_CYC)
                             ? ((SETUP_CYC > REC_CYC) ? SETUP_CYC : REC_CYC)
                             : ((RD_LOW_CYC > REC_CYC) ? RD_LOW_CYC : REC_CYC);
    localparam int c_TMR_W   = tdc_width(c_TMR_MAX);

    localparam logic [c_TMR_W-1:0] c_T_SETUP = c_TMR_W'(SETUP_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_T_LOW   = c_TMR_W'(RD_LOW_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_T_REC   = c_TMR_W'(REC_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_MAXB    = c_CNT_W'(MAX_BURST);
    localparam logic [c_CHAN_W-1:0] c_LAST   = c_CHAN_W'(N_FIFO - 1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [N_FIFO-1:0]    r_ef_s1;
    logic [N_FIFO-1:0]    r_ef_s2;
    logic [N_FIFO-1:0]    w_nonempty;
    logic [c_CHAN_W-1:0]  w_pick;
    logic                 w_any;
    logic [ADDR_W-1:0]    w_pick_addr;
    logic                 w_start_edge;

    tdc_state_t           r_state;
    logic                 r_start_d;
    logic                 r_mode;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [c_CHAN_W-1:0]  r_sel;
    logic [c_CHAN_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_csn;
    logic                 r_rdn;
    logic                 r_m_valid;
    logic [DATA_W-1:0]    r_m_data;
    logic [c_CHAN_W-1:0]  r_m_chan;
    logic                 r_done;
    logic                 r_alu;
    logic [c_CNT_W-1:0]   r_word_cnt;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ef_s1 <= '1;
            r_ef_s2 <= '1;
        end else begin
            r_ef_s1 <= ef;
            r_ef_s2 <= r_ef_s1;
        end
    end

    assign w_nonempty   = ~r_ef_s2;
    assign w_start_edge = start & ~r_start_d;
    assign w_pick_addr  = ADDR_W'(FIFO_ADDR0) + ADDR_W'(w_pick);

    tdc_rr_arbiter #(
        .N_FIFO (N_FIFO),
        .IDX_W  (c_CHAN_W)
    ) u_arb (
        .i_req  (w_nonempty),
        .i_ptr  (r_rr_ptr),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_start_d  <= 1'b0;
            r_mode     <= 1'b0;
            r_tmr      <= '0;
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_addr     <= '0;
            r_csn      <= 1'b1;
            r_rdn      <= 1'b1;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_chan   <= '0;
            r_done     <= 1'b0;
            r_alu      <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_start_d <= start;
            r_done    <= 1'b0;
            r_alu     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_mode     <= burst;
                        r_word_cnt <= '0;
                        if (w_any) begin
                            r_sel   <= w_pick;
                            r_addr  <= w_pick_addr;
                            r_tmr   <= c_T_SETUP;
                            r_state <= S_SETUP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_tmr == '0) begin
                        r_csn   <= 1'b0;
                        r_rdn   <= 1'b0;
                        r_tmr   <= c_T_LOW;
                        r_state <= S_STROBE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (r_tmr == '0) begin
                        r_m_data   <= tdc_data;
                        r_m_chan   <= r_sel;
                        r_csn      <= 1'b1;
                        r_rdn      <= 1'b1;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_state    <= S_CAPTURE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_m_valid <= 1'b1;
                    r_state   <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_rr_ptr  <= (r_sel == c_LAST) ? '0 : r_sel + 1'b1;
                        r_tmr     <= c_T_REC;
                        r_state   <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    if (r_tmr != '0) begin
                        r_tmr <= r_tmr - 1'b1;
                    end else if (!r_mode || (r_word_cnt == c_MAXB) || !w_any) begin
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                        r_alu   <= (r_word_cnt != '0);
                        r_state <= S_FINISH;
                    end else begin
                        r_sel   <= w_pick;
                        r_addr  <= w_pick_addr;
                        r_tmr   <= c_T_SETUP;
                        r_state <= S_SETUP;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tdc_addr    = r_addr;
    assign tdc_csn     = r_csn;
    assign tdc_rdn     = r_rdn;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_chan      = r_m_chan;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign word_cnt    = r_word_cnt;
    assign alu_trigger = r_alu;

endmodule
`default_nettype wire

// File: tb/tb_tdc_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdc_burst_reader
// Randomised bench with a TDC FIFO model, reference model and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tdc_burst_reader;

    localparam int DW   = 28;
    localparam int AW   = 4;
    localparam int NF   = 2;
    localparam int LOWC = 2;
    localparam int MAXB = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          burst;
    logic [NF-1:0] ef;
    logic [DW-1:0] tdc_data = '0;
    logic [AW-1:0] tdc_addr;
    logic          tdc_csn;
    logic          tdc_rdn;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_chan;
    logic          busy;
    logic          done;
    logic [4:0]    word_cnt;
    logic          alu_trigger;

    always #5 clk = ~clk;

    tdc_burst_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .burst       (burst),
        .ef          (ef),
        .tdc_data    (tdc_data),
        .tdc_addr    (tdc_addr),
        .tdc_csn     (tdc_csn),
        .tdc_rdn     (tdc_rdn),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_chan      (m_chan),
        .busy        (busy),
        .done        (done),
        .word_cnt    (word_cnt),
        .alu_trigger (alu_trigger)
    );

    logic [DW-1:0] fq0[$];
    logic [DW-1:0] fq1[$];
    logic [DW:0]   exp_q[$];
    int            exp_cnt_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int done_seen = 0;
    int n_strobes = 0;
    int n_exp_words = 0;
    int lowcnt = 0;
    int mptr = 0;
    int s_ch = 0;
    bit in_strobe = 1'b0;
    bit mon_en = 1'b0;
    bit rnd_rdy = 1'b0;
    bit rdy_fix = 1'b1;

    logic          p_rdn = 1'b1;
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic          p_done = 1'b0;
    logic          p_chan = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [AW-1:0] last_saddr = '0;
    logic [DW-1:0] p_data = '0;
    logic [DW:0]   mon_e;
    int            mon_c;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void upd_ef();
        ef = {fq1.size() == 0, fq0.size() == 0};
    endfunction

    task automatic fill(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) fq0.push_back(DW'($urandom));
            else         fq1.push_back(DW'($urandom));
        end
        upd_ef();
    endtask

    // TDC device model: presents the head word during RDN low, pops it on RDN rise.
    always @(tdc_rdn) begin
        if (tdc_rdn === 1'b0) begin
            in_strobe = 1'b1;
            s_ch = (tdc_addr == 4'd9) ? 1 : 0;
            if (s_ch == 1) tdc_data = (fq1.size() > 0) ? fq1[0] : '1;
            else           tdc_data = (fq0.size() > 0) ? fq0[0] : '1;
        end else if (tdc_rdn === 1'b1 && in_strobe) begin
            in_strobe = 1'b0;
            if (s_ch == 1) begin
                if (fq1.size() > 0) void'(fq1.pop_front());
            end else begin
                if (fq0.size() > 0) void'(fq0.pop_front());
            end
            upd_ef();
        end
    end

    // Reference: round-robin over the FIFO contents as they stand at start.
    function automatic void build_expect(input bit mode);
        logic [DW-1:0] c0[$];
        logic [DW-1:0] c1[$];
        int n = 0;
        int ch;
        c0 = fq0;
        c1 = fq1;
        while (c0.size() + c1.size() > 0) begin
            if (mptr == 0) ch = (c0.size() > 0) ? 0 : 1;
            else           ch = (c1.size() > 0) ? 1 : 0;
            if (ch == 0) exp_q.push_back({1'b0, c0.pop_front()});
            else         exp_q.push_back({1'b1, c1.pop_front()});
            mptr = (ch + 1) % NF;
            n++;
            if (!mode || n == MAXB) break;
        end
        exp_cnt_q.push_back(n);
        n_exp_words += n;
    endfunction

    always @(posedge clk) begin
        #1;
        m_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            chk(tdc_csn == tdc_rdn, "csn_eq_rdn", tdc_csn, tdc_rdn);
            if (!busy) chk(tdc_addr == '0, "idle_addr", tdc_addr, 0);
            if (!tdc_rdn) begin
                lowcnt++;
                chk(tdc_addr == p_addr, "addr_setup_stable", tdc_addr, p_addr);
                chk(tdc_addr == 4'd8 || tdc_addr == 4'd9, "strobe_addr_range", tdc_addr, 8);
                chk(!m_valid, "strobe_while_valid", m_valid, 0);
                last_saddr = tdc_addr;
            end else if (!p_rdn) begin
                chk(lowcnt == LOWC, "rdn_low_width", lowcnt, LOWC);
                n_strobes++;
                lowcnt = 0;
            end
            if (p_valid && !p_ready) begin
                chk(m_valid, "valid_held", m_valid, 1);
                chk(m_data == p_data, "data_held", m_data, p_data);
                chk(m_chan == p_chan, "chan_held", m_chan, p_chan);
            end
            if (m_valid && m_ready) begin
                chk(exp_q.size() != 0, "unexpected_word", m_data, 0);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk(m_data == mon_e[DW-1:0], "word_data", m_data, mon_e[DW-1:0]);
                    chk(m_chan == mon_e[DW], "word_chan", m_chan, mon_e[DW]);
                end
            end
            if (done) begin
                chk(!p_done, "done_one_clock", p_done, 0);
                chk(exp_cnt_q.size() != 0, "unexpected_done", done, 0);
                if (exp_cnt_q.size() != 0) begin
                    mon_c = exp_cnt_q.pop_front();
                    chk(word_cnt == 5'(mon_c), "word_cnt", word_cnt, mon_c);
                    chk(alu_trigger == (mon_c != 0), "alu_trigger", alu_trigger, mon_c != 0);
                end
                done_seen++;
            end else begin
                chk(!alu_trigger, "alu_without_done", alu_trigger, 0);
            end
        end
        p_rdn   = tdc_rdn;
        p_addr  = tdc_addr;
        p_valid = m_valid;
        p_ready = m_ready;
        p_data  = m_data;
        p_chan  = m_chan;
        p_done  = done;
    end

    task automatic settle();
        repeat (4) @(posedge clk);
    endtask

    task automatic do_start(input bit mode);
        @(posedge clk);
        #1;
        burst = mode;
        start = 1'b1;
        build_expect(mode);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int t = 0;
        while (done_seen == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk(done_seen != d0, name, done_seen, d0 + 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tdc_csn == 1'b1, {tag, "_csn"}, tdc_csn, 1);
        chk(tdc_rdn == 1'b1, {tag, "_rdn"}, tdc_rdn, 1);
        chk(tdc_addr == '0, {tag, "_addr"}, tdc_addr, 0);
        chk(m_valid == 1'b0, {tag, "_m_valid"}, m_valid, 0);
        chk(done == 1'b0, {tag, "_done"}, done, 0);
        chk(alu_trigger == 1'b0, {tag, "_alu"}, alu_trigger, 0);
        chk(word_cnt == '0, {tag, "_word_cnt"}, word_cnt, 0);
        chk(m_data == '0, {tag, "_m_data"}, m_data, 0);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int d0;
        int s0;
        int t;
        reset_n = 1'b0;
        start   = 1'b0;
        burst   = 1'b0;
        upd_ef();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        mon_en = 1'b1;

        // Single word from FIFO 0
        fq0.push_back(28'h0ABCDEF);
        upd_ef();
        settle();
        d0 = done_seen;
        do_start(1'b0);
        wait_done(d0, "single_done_timeout");
        chk(last_saddr == 4'd8, "single_addr", last_saddr, 8);
        chk(word_cnt == 5'd1, "single_cnt_held", word_cnt, 1);

        // Single word from FIFO 1 returns the pointer to FIFO 0
        fill(1, 1);
        settle();
        d0 = done_seen;
        do_start(1'b0);
        wait_done(d0, "single1_done_timeout");
        chk(last_saddr == 4'd9, "single1_addr", last_saddr, 9);

        // Drain 3 + 2 words: alternating 0,1,0,1,0
        fill(0, 3);
        fill(1, 2);
        settle();
        d0 = done_seen;
        do_start(1'b1);
        wait_done(d0, "drain5_done_timeout");
        chk(word_cnt == 5'd5, "drain5_cnt", word_cnt, 5);
        chk(ef == 2'b11, "drain5_empty", ef, 3);

        // All FIFOs empty: no strobe, word_cnt 0
        s0 = n_strobes;
        settle();
        d0 = done_seen;
        do_start(1'b1);
        wait_done(d0, "empty_done_timeout");
        chk(n_strobes == s0, "empty_no_strobe", n_strobes, s0);

        // Burst cap with a stray start edge while busy
        fill(0, 40);
        fill(1, 40);
        settle();
        d0 = done_seen;
        do_start(1'b1);
        repeat (30) @(posedge clk);
        #1;
        chk(busy == 1'b1, "cap_busy", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0, "cap_done_timeout");
        chk(word_cnt == 5'd16, "cap_cnt", word_cnt, 16);
        chk(ef == 2'b00, "cap_flags_low", ef, 0);
        chk(fq0.size() + fq1.size() == 64, "cap_left", fq0.size() + fq1.size(), 64);
        repeat (40) @(posedge clk);
        #1;
        chk(busy == 1'b0, "cap_no_requeue", busy, 0);
        chk(done_seen == d0 + 1, "cap_one_done", done_seen, d0 + 1);

        // Output stall: word held, no new strobe
        rdy_fix = 1'b0;
        settle();
        d0 = done_seen;
        do_start(1'b0);
        t = 0;
        while (!m_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(m_valid, "stall_valid_seen", m_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        chk(m_valid == 1'b1, "stall_valid_after10", m_valid, 1);
        rdy_fix = 1'b1;
        wait_done(d0, "stall_done_timeout");

        // Randomised traffic
        for (int it = 0; it < 20; it++) begin
            fill(0, $urandom_range(0, 4));
            fill(1, $urandom_range(0, 4));
            rnd_rdy = 1'b1;
            settle();
            d0 = done_seen;
            do_start(1'($urandom_range(0, 1)));
            wait_done(d0, "rand_done_timeout");
            rnd_rdy = 1'b0;
        end

        // Reset in the middle of a strobe
        fill(0, 3);
        settle();
        do_start(1'b1);
        t = 0;
        while (tdc_rdn && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(!tdc_rdn, "rst_strobe_seen", tdc_rdn, 0);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_cnt_q.delete();
        mptr = 0;
        n_strobes = 0;
        n_exp_words = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        lowcnt = 0;
        mon_en = 1'b1;
        fill(0, 1);
        settle();
        d0 = done_seen;
        do_start(1'b0);
        wait_done(d0, "post_rst_done_timeout");
        chk(word_cnt == 5'd1, "post_rst_cnt", word_cnt, 1);

        repeat (5) @(posedge clk);
        chk(exp_q.size() == 0, "words_outstanding", exp_q.size(), 0);
        chk(exp_cnt_q.size() == 0, "bursts_outstanding", exp_cnt_q.size(), 0);
        chk(n_strobes == n_exp_words, "strobe_total", n_strobes, n_exp_words);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
